// File: rtl/mem_bus_if.sv
// MEM-stage bus interface: one-cycle scratch-pad accesses, and everything else
// runs as a request/grant/ready bus transaction while the pipeline is held with busy.
module mem_bus_if #(
  parameter logic [2:0] SPM_SEL = 3'b011,
  parameter int         SPM_AW  = 12
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic [29:0]       addr,
  input  logic              as_,
  input  logic              rw,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  input  logic [31:0]       spm_rd_data,
  output logic [SPM_AW-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [31:0]       spm_wr_data,
  input  logic [31:0]       bus_rd_data,
  input  logic              bus_rdy_,
  input  logic              bus_grnt_,
  output logic              bus_req_,
  output logic [29:0]       bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [31:0]       bus_wr_data
);

  localparam logic READ = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  state_t      state;
  logic [31:0] rd_buf;
  logic        spm_hit;

  assign spm_hit     = (addr[29:27] == SPM_SEL);
  assign spm_addr    = addr[SPM_AW-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_as_     = (state == IDLE && !flush && !as_ && spm_hit) ? 1'b0 : 1'b1;

  // A stalled SPM load returns zero; WAIT replays the buffered bus load until the stall clears.
  always_comb begin
    busy    = 1'b0;
    rd_data = '0;
    case (state)
      IDLE: begin
        if (!flush && !as_) begin
          if (spm_hit) begin
            if (!stall) rd_data = spm_rd_data;
          end else begin
            busy = 1'b1;
          end
        end
      end
      REQ: busy = 1'b1;
      ACCESS: begin
        if (!bus_rdy_) begin
          if (bus_rw == READ) rd_data = bus_rd_data;
        end else begin
          busy = 1'b1;
        end
      end
      WAIT: rd_data = rd_buf;
      default: ;
    endcase
  end

  // Once launched, a transaction ignores flush and runs until ready is seen.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      bus_req_    <= 1'b1;
      bus_addr    <= '0;
      bus_as_     <= 1'b1;
      bus_rw      <= READ;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && !as_ && !spm_hit) begin
            state       <= REQ;
            bus_req_    <= 1'b0;
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
          end
        end
        REQ: begin
          if (!bus_grnt_) begin
            state   <= ACCESS;
            bus_as_ <= 1'b0;
          end
        end
        ACCESS: begin
          bus_as_ <= 1'b1;
          if (!bus_rdy_) begin
            bus_req_    <= 1'b1;
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
            if (bus_rw == READ) rd_buf <= bus_rd_data;
            state <= stall ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: a table of single-cycle IDLE vectors, directed
// bus sequences, and randomized transactions checked against a transaction-level model.
module tb_mem_bus_if;

  localparam int SPM_AW = 12;

  logic              clk = 1'b0;
  logic              reset_;
  logic              stall, flush, busy;
  logic [29:0]       addr;
  logic              as_, rw;
  logic [31:0]       wr_data, rd_data, spm_rd_data;
  logic [SPM_AW-1:0] spm_addr;
  logic              spm_as_, spm_rw;
  logic [31:0]       spm_wr_data, bus_rd_data;
  logic              bus_rdy_, bus_grnt_, bus_req_;
  logic [29:0]       bus_addr;
  logic              bus_as_, bus_rw;
  logic [31:0]       bus_wr_data;

  mem_bus_if #(.SPM_SEL(3'b011), .SPM_AW(SPM_AW)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_read = '0;

  typedef struct {
    logic        as_n;
    logic        fl;
    logic        st;
    logic [29:0] a;
    logic        r_w;
    logic [31:0] srd;
    logic        exp_busy;
    logic [31:0] exp_rd;
    logic        exp_spm_as_;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic a_n, input logic fl, input logic st, input logic [29:0] a,
                               input logic r_w, input logic [31:0] wd, input logic [31:0] srd);
    as_ = a_n; flush = fl; stall = st; addr = a; rw = r_w; wr_data = wd; spm_rd_data = srd;
  endtask

  function automatic logic rbit();
    logic [31:0] v;
    v = $urandom;
    return v[0];
  endfunction

  function automatic logic [29:0] rand_addr();
    logic [31:0] v;
    v = $urandom;
    return v[29:0];
  endfunction

  function automatic logic [29:0] rand_bus_addr();
    logic [31:0] v;
    v = $urandom;
    if (v[29:27] == 3'b011) v[29] = 1'b1;
    return v[29:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One quiet IDLE cycle; also confirms the bus side is back at rest.
  task automatic go_idle(input string tag);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, '0, '0);
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = $urandom;
    @(negedge clk);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " idle req_"}, 32'(bus_req_), 32'd1);
    checkOutput({tag, " idle as_"}, 32'(bus_as_), 32'd1);
    checkOutput({tag, " idle bus_addr"}, 32'(bus_addr), 32'd0);
  endtask

  task automatic run_spm(input string tag, input logic [29:0] a, input logic r_w,
                         input logic [31:0] wd, input logic [31:0] srd, input logic st);
    next_cycle();
    applyStimulus(1'b0, 1'b0, st, a, r_w, wd, srd);
    @(negedge clk);
    checkOutput({tag, " spm_as_"}, 32'(spm_as_), 32'd0);
    checkOutput({tag, " spm_addr"}, 32'(spm_addr), 32'(a[SPM_AW-1:0]));
    checkOutput({tag, " spm_rw"}, 32'(spm_rw), 32'(r_w));
    checkOutput({tag, " spm_wr_data"}, spm_wr_data, wd);
    checkOutput({tag, " rd_data"}, rd_data, st ? 32'd0 : srd);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    go_idle(tag);
  endtask

  // g: REQ cycles without grant, r: ACCESS cycles without ready, s: WAIT cycles (last one unstalled).
  task automatic run_bus(input string tag, input logic [29:0] a, input logic r_w, input logic [31:0] wd,
                         input logic [31:0] rdv, input int g, input int r, input int s);
    int busy_cnt = 0;
    int req_cnt  = 0;
    int as_cnt   = 0;
    int hold_bad = 0;
    int ready_k  = g + r + 2;
    for (int k = 0; k <= ready_k; k++) begin
      next_cycle();
      if (k == 0) begin
        applyStimulus(1'b0, 1'b0, rbit(), a, r_w, wd, $urandom);
      end else begin
        applyStimulus(rbit(), rbit(), (k == ready_k) ? (s > 0) : rbit(), rand_addr(), rbit(), $urandom, $urandom);
      end
      bus_grnt_   = (k >= g + 1) ? 1'b0 : 1'b1;
      bus_rdy_    = (k == ready_k) ? 1'b0 : ((k >= 1 && k <= g + 1) ? rbit() : 1'b1);
      bus_rd_data = (k == ready_k) ? rdv : $urandom;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (!bus_req_) req_cnt++;
      if (!bus_as_) as_cnt++;
      if (k >= 1 && (bus_addr !== a || bus_rw !== r_w || bus_wr_data !== wd)) hold_bad++;
      if (k == 0) checkOutput({tag, " req_ at launch"}, 32'(bus_req_), 32'd1);
      if (k == ready_k) begin
        checkOutput({tag, " rd_data at ready"}, rd_data, r_w ? rdv : 32'd0);
        checkOutput({tag, " busy at ready"}, 32'(busy), 32'd0);
      end
    end
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(g + r + 2));
    checkOutput({tag, " req_ low cycles"}, 32'(req_cnt), 32'(g + r + 2));
    checkOutput({tag, " as_ low cycles"}, 32'(as_cnt), 32'd1);
    checkOutput({tag, " held bus fields"}, 32'(hold_bad), 32'd0);
    if (r_w) last_read = rdv;
    for (int w = 0; w < s; w++) begin
      next_cycle();
      applyStimulus(rbit(), rbit(), (w < s - 1), rand_addr(), rbit(), $urandom, $urandom);
      bus_rdy_ = rbit(); bus_grnt_ = rbit();
      @(negedge clk);
      checkOutput({tag, " wait rd_data"}, rd_data, last_read);
      checkOutput({tag, " wait busy"}, 32'(busy), 32'd0);
    end
    go_idle(tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 30'h1800_0004, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0,         1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 30'h1800_0004, 1'b1, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 30'h1800_0004, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 30'h0000_0010, 1'b1, 32'h1111_2222, 1'b0, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 30'h1800_0004, 1'b1, 32'h3333_4444, 1'b0, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 30'h1FFF_FFFF, 1'b0, 32'h0000_0055, 1'b0, 32'h0000_0055, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 30'h0000_0020, 1'b0, 32'h6666_7777, 1'b0, 32'h0,         1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 30'h1800_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};

    reset_ = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, '0, '0);
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rd_data", rd_data, 32'd0);
    checkOutput("reset bus_req_", 32'(bus_req_), 32'd1);
    checkOutput("reset bus_as_", 32'(bus_as_), 32'd1);
    checkOutput("reset bus_addr", 32'(bus_addr), 32'd0);
    checkOutput("reset bus_rw", 32'(bus_rw), 32'd1);
    checkOutput("reset bus_wr_data", bus_wr_data, 32'd0);
    reset_ = 1'b1;

    for (int i = 0; i < 8; i++) begin
      next_cycle();
      applyStimulus(vecs[i].as_n, vecs[i].fl, vecs[i].st, vecs[i].a, vecs[i].r_w, 32'h0BAD_F00D, vecs[i].srd);
      @(negedge clk);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d spm_as_", i), 32'(spm_as_), 32'(vecs[i].exp_spm_as_));
      checkOutput($sformatf("vec%0d spm_addr", i), 32'(spm_addr), 32'(vecs[i].a[SPM_AW-1:0]));
      checkOutput($sformatf("vec%0d bus_req_", i), 32'(bus_req_), 32'd1);
    end
    go_idle("after vectors");

    run_spm("spm read", 30'h1800_0004, 1'b1, 32'h0, 32'hCAFE_0001, 1'b0);
    run_bus("bus read", 30'h0000_0010, 1'b1, 32'h0, 32'h1234_5678, 2, 2, 0);
    run_bus("bus write", 30'h0000_0040, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0, 0);
    run_bus("stalled read", 30'h0200_0100, 1'b1, 32'h0, 32'hDEAD_BEEF, 1, 1, 3);
    run_bus("stalled write", 30'h2000_0008, 1'b0, 32'h0F0F_0F0F, 32'h7777_7777, 0, 1, 2);

    // Reset in the first ACCESS cycle must clear the bus side without a clock edge.
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0000_0100, 1'b1, 32'h0, 32'h0);
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
    next_cycle();
    next_cycle();
    checkOutput("access bus_as_ before reset", 32'(bus_as_), 32'd0);
    as_ = 1'b1;
    reset_ = 1'b0;
    #1;
    checkOutput("async reset bus_req_", 32'(bus_req_), 32'd1);
    checkOutput("async reset bus_as_", 32'(bus_as_), 32'd1);
    checkOutput("async reset bus_addr", 32'(bus_addr), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_ = 1'b1;
    last_read = '0;
    go_idle("after reset");
    run_bus("wait after reset", 30'h0000_0200, 1'b0, 32'h1, 32'h0, 0, 0, 1);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] d;
      d = $urandom;
      case ($urandom_range(0, 3))
        0: run_spm($sformatf("rnd%0d spm", t), {3'b011, d[26:0]}, rbit(), $urandom, $urandom, rbit());
        1: run_bus($sformatf("rnd%0d rd", t), rand_bus_addr(), 1'b1, $urandom, d,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        2: run_bus($sformatf("rnd%0d wr", t), rand_bus_addr(), 1'b0, d, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        default: begin
          next_cycle();
          applyStimulus(1'b0, 1'b1, rbit(), rand_bus_addr(), rbit(), $urandom, $urandom);
          @(negedge clk);
          checkOutput($sformatf("rnd%0d flush busy", t), 32'(busy), 32'd0);
          checkOutput($sformatf("rnd%0d flush rd_data", t), rd_data, 32'd0);
          go_idle($sformatf("rnd%0d flush", t));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
